cart_mem_arb: RTL and testbench
===============================

CART_MEM_ARB -- requirements
Module: cart_mem_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter ADDR_W, default 18: shared-memory byte address width.
REQ-003 Parameter MEM_LAT, default 2: fixed read latency of the memory, in cycles, from mem_en to valid mem_rdata; legal range 1-4.
REQ-004 Parameter CPU_MAX_WAIT, default 4: number of cycles a blocked CPU request waits before it overrides PPU priority; legal range 1-15.
REQ-005 clk  in  1  clock for the arbiter and the shared memory.
REQ-006 rst_n  in  1  asynchronous reset, active low.
REQ-007 ppu_req, cpu_req, ld_req  in  1 each  request from the PPU CHR port, the CPU PRG port and the cartridge loader.
REQ-008 ppu_addr, cpu_addr, ld_addr  in  ADDR_W each  request address.
REQ-009 ppu_we, cpu_we, ld_we  in  1 each  request is a write when 1 and a read when 0.
REQ-010 ppu_wdata, cpu_wdata, ld_wdata  in  8 each  write data.
REQ-011 ppu_ack, cpu_ack, ld_ack  out  1 each  single-cycle pulse marking that the access was issued.
REQ-012 ppu_rvalid, cpu_rvalid, ld_rvalid  out  1 each  single-cycle pulse marking that rdata belongs to that requester.
REQ-013 rdata  out  8  read data, shared by all requesters and qualified by the rvalid signals.
REQ-014 mem_en, mem_we  out  1 each  memory access strobe and write enable.
REQ-015 mem_addr  out  ADDR_W  memory address.
REQ-016 mem_wdata  out  8  memory write data.
REQ-017 mem_rdata  in  8  memory read data.

Function
REQ-018 Eligibility: a requester SHALL be eligible in a cycle when its req is 1 and its own ack is 0.
- Consequence: a single requester is granted at most once every 2 cycles.
REQ-019 Grant rate: at most one requester SHALL be granted per cycle.
REQ-020 Priority order SHALL be PPU, then CPU, then loader, except as stated in REQ-023.
REQ-021 Grant timing: the grant decision SHALL be made from the inputs sampled at edge N.
- At edge N, mem_en, mem_we, mem_addr and mem_wdata are registered from the winner.
- The winner's ack is registered high for cycle N+1 only.
- When nothing is granted, mem_en and mem_we are 0.
REQ-022 Requester obligation: req, addr, we and wdata SHALL be held stable until ack is sampled high; the arbiter's behaviour is undefined if a requester drops req before ack.
REQ-023 CPU wait counter (4 bits, saturating at CPU_MAX_WAIT):
- increments every cycle the CPU is eligible but not granted;
- clears when the CPU is granted or cpu_req is 0;
- while it equals CPU_MAX_WAIT, the CPU outranks the PPU.
REQ-024 The loader SHALL never raise the CPU wait counter, and it has no starvation protection.
REQ-025 Read return: for a granted read, the owner's rvalid SHALL pulse exactly MEM_LAT cycles after its ack cycle.
- rdata = mem_rdata in that cycle.
- Writes produce no rvalid.
REQ-026 In-flight tags: the owner of each in-flight read SHALL be tracked in a MEM_LAT-deep tag pipeline.
- Back-to-back reads from different requesters return in issue order, one per cycle.
REQ-027 rdata SHALL be 0 in any cycle in which no rvalid is high.
REQ-028 When all three requesters are eligible and the counter is below CPU_MAX_WAIT, the PPU SHALL win.

Reset
REQ-029 While rst_n is low, the following SHALL all be 0: every ack, every rvalid, mem_en, mem_we, mem_addr, mem_wdata, rdata, the CPU wait counter, and every tag.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight reads, so no rvalid is produced for them after reset release.
REQ-031 The first grant after reset release SHALL occur no earlier than the first clock edge at which rst_n is sampled high.

Structure
REQ-032 Package cart_pkg SHALL hold:
- enum owner_t {OWN_NONE, OWN_PPU, OWN_CPU, OWN_LD};
- the default values of ADDR_W, MEM_LAT and CPU_MAX_WAIT.
REQ-033 The tag pipeline SHALL be one sub-module, cart_arb_tagpipe: a MEM_LAT-deep shift register of owner_t, cleared by reset.
REQ-034 The grant logic, the wait counter and the output registers SHALL remain in cart_mem_arb.

Verification
REQ-035 Single PPU read: PPU read of 0x01234, MEM_LAT=2, memory returns 0xA5 -> ppu_ack in cycle 1; ppu_rvalid in cycle 3 with rdata=0xA5; no other ack or rvalid.
REQ-036 Three-way contention: all three eligible simultaneously -> PPU acked first; CPU acked next cycle; loader acked only after both have dropped req.
REQ-037 CPU starvation: PPU req held continuously and CPU req held, CPU_MAX_WAIT=4 -> cpu_ack no later than 5 cycles after cpu_req rises; counter returns to 0.
REQ-038 Interleaved reads: PPU read, CPU read, PPU read in 3 consecutive grant cycles, with mem_rdata 0x11, 0x22, 0x33 -> rvalid pulses in order ppu, cpu, ppu with matching data.
REQ-039 Write then read: loader writes 0x5A to 0x00010, then CPU reads 0x00010 -> mem_we=1 only in the write cycle; no ld_rvalid; cpu_rvalid with rdata=0x5A.
REQ-040 Reset mid-read: rst_n pulsed low 1 cycle after a CPU read ack -> no cpu_rvalid afterwards; all outputs 0 during reset.

Source files
------------

// File: rtl/cart_pkg.sv
// Cartridge memory arbiter: shared types and parameter defaults.
//   owner_t          - identifies which requester owns an access / in-flight read
//   *_DEF constants  - default ADDR_W, MEM_LAT and CPU_MAX_WAIT for cart_mem_arb
package cart_pkg;

    localparam int ADDR_W_DEF       = 18;
    localparam int MEM_LAT_DEF      = 2;
    localparam int CPU_MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_PPU,
        OWN_CPU,
        OWN_LD
    } owner_t;

endpackage

// File: rtl/cart_arb_tagpipe.sv
// In-flight read tag pipeline for cart_mem_arb.
// A DEPTH-deep shift register of owner_t; tag_out is the owner of the read
// whose data is on mem_rdata this cycle (OWN_NONE when no read returns).
//   clk, rst_n : clock, async active-low reset (clears every stage)
//   tag_in     : owner of the access issued this cycle (OWN_NONE for writes/idle)
//   tag_out    : owner of the read returning this cycle
module cart_arb_tagpipe
    import cart_pkg::*;
#(
    parameter int DEPTH = MEM_LAT_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  owner_t tag_in,
    output owner_t tag_out
);

    owner_t pipe_d [DEPTH];
    owner_t pipe_q [DEPTH];

    always_comb begin
        pipe_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= OWN_NONE;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/cart_mem_arb.sv
// Shared cartridge memory arbiter for PPU (CHR), CPU (PRG) and the loader.
// One access is issued per cycle; priority PPU > CPU > loader, except that a
// CPU that has waited CPU_MAX_WAIT eligible cycles outranks the PPU.
//   clk, rst_n                 : clock, async active-low reset
//   {ppu,cpu,ld}_req/addr/we/wdata : requests, held until ack
//   {ppu,cpu,ld}_ack           : one-cycle pulse, access issued
//   {ppu,cpu,ld}_rvalid, rdata : read return, MEM_LAT cycles after ack
//   mem_en/we/addr/wdata       : registered memory command
//   mem_rdata                  : memory read data, MEM_LAT cycles after mem_en
module cart_mem_arb
    import cart_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int MEM_LAT      = MEM_LAT_DEF,
    parameter int CPU_MAX_WAIT = CPU_MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic              ppu_we,
    input  logic [7:0]        ppu_wdata,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_wdata,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_we,
    input  logic [7:0]        ld_wdata,
    output logic              ppu_ack,
    output logic              cpu_ack,
    output logic              ld_ack,
    output logic              ppu_rvalid,
    output logic              cpu_rvalid,
    output logic              ld_rvalid,
    output logic [7:0]        rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam logic [3:0] WAIT_MAX = 4'(CPU_MAX_WAIT);

    logic              ppu_elig, cpu_elig, ld_elig, cpu_urgent;
    owner_t            win;
    logic [2:0]        ack_d, ack_q;          // {ld, cpu, ppu}
    logic              mem_en_d, mem_en_q, mem_we_d, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic [7:0]        mem_wdata_d, mem_wdata_q;
    logic [3:0]        cpu_wait_d, cpu_wait_q;
    owner_t            rd_own_d, rd_own_q;
    owner_t            ret_own;

    always_comb begin
        // A requester whose ack is high this cycle is still presenting the
        // request it was just granted, so it must sit out one cycle.
        ppu_elig   = ppu_req & ~ack_q[0];
        cpu_elig   = cpu_req & ~ack_q[1];
        ld_elig    = ld_req  & ~ack_q[2];
        cpu_urgent = (cpu_wait_q == WAIT_MAX);

        win = OWN_NONE;
        if (cpu_elig && cpu_urgent) win = OWN_CPU;
        else if (ppu_elig)          win = OWN_PPU;
        else if (cpu_elig)          win = OWN_CPU;
        else if (ld_elig)           win = OWN_LD;

        ack_d       = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (win)
            OWN_PPU: begin
                ack_d[0] = 1'b1; mem_en_d = 1'b1; mem_we_d = ppu_we;
                mem_addr_d = ppu_addr; mem_wdata_d = ppu_wdata;
            end
            OWN_CPU: begin
                ack_d[1] = 1'b1; mem_en_d = 1'b1; mem_we_d = cpu_we;
                mem_addr_d = cpu_addr; mem_wdata_d = cpu_wdata;
            end
            OWN_LD: begin
                ack_d[2] = 1'b1; mem_en_d = 1'b1; mem_we_d = ld_we;
                mem_addr_d = ld_addr; mem_wdata_d = ld_wdata;
            end
            default: ;
        endcase

        // Only reads get a tag; writes return nothing.
        rd_own_d = (mem_en_d && !mem_we_d) ? win : OWN_NONE;

        // Saturating wait count; the loader never feeds it.
        if (!cpu_req || win == OWN_CPU)
            cpu_wait_d = 4'd0;
        else if (cpu_elig && cpu_wait_q < WAIT_MAX)
            cpu_wait_d = cpu_wait_q + 4'd1;
        else
            cpu_wait_d = cpu_wait_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_wait_q  <= '0;
            rd_own_q    <= OWN_NONE;
        end else begin
            ack_q       <= ack_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_wait_q  <= cpu_wait_d;
            rd_own_q    <= rd_own_d;
        end
    end

    // rd_own_q is valid in the ack cycle (same cycle as mem_en), so a
    // MEM_LAT-deep pipe lines the tag up with mem_rdata.
    cart_arb_tagpipe #(.DEPTH(MEM_LAT)) u_tagpipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .tag_in (rd_own_q),
        .tag_out(ret_own)
    );

    assign ppu_ack    = ack_q[0];
    assign cpu_ack    = ack_q[1];
    assign ld_ack     = ack_q[2];
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign ppu_rvalid = (ret_own == OWN_PPU);
    assign cpu_rvalid = (ret_own == OWN_CPU);
    assign ld_rvalid  = (ret_own == OWN_LD);
    assign rdata      = (ret_own != OWN_NONE) ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_cart_mem_arb.sv
// Bench for cart_mem_arb: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model (grant choice, expected read
// returns scheduled by cycle number, reference memory contents).
module tb_cart_mem_arb;

    localparam int ADDR_W  = 18;
    localparam int MEM_LAT = 2;
    localparam int MAXW    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] req = '0;   // index 0 = PPU, 1 = CPU, 2 = loader
    logic [2:0] we  = '0;
    logic [ADDR_W-1:0] addr [3];
    logic [7:0] wdata [3];
    logic ppu_ack, cpu_ack, ld_ack, ppu_rvalid, cpu_rvalid, ld_rvalid;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;

    int total = 0, bad = 0, cyc = 0;

    always #5 clk = ~clk;

    cart_mem_arb #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .CPU_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ppu_req(req[0]), .ppu_addr(addr[0]), .ppu_we(we[0]), .ppu_wdata(wdata[0]),
        .cpu_req(req[1]), .cpu_addr(addr[1]), .cpu_we(we[1]), .cpu_wdata(wdata[1]),
        .ld_req(req[2]),  .ld_addr(addr[2]),  .ld_we(we[2]),  .ld_wdata(wdata[2]),
        .ppu_ack(ppu_ack), .cpu_ack(cpu_ack), .ld_ack(ld_ack),
        .ppu_rvalid(ppu_rvalid), .cpu_rvalid(cpu_rvalid), .ld_rvalid(ld_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Unwritten locations read back a fixed function of the address.
    function automatic logic [7:0] dflt(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'h5C;
    endfunction

    // ---------------- memory with fixed MEM_LAT read latency ----------------
    logic [7:0]    mem [4096];
    logic [4095:0] mem_wr = '0;
    logic [7:0]    rpipe [MEM_LAT];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr[11:0]]    <= mem_wdata;
            mem_wr[mem_addr[11:0]] <= 1'b1;
        end
        rpipe[0] <= mem_wr[mem_addr[11:0]] ? mem[mem_addr[11:0]] : dflt(mem_addr);
        for (int i = 1; i < MEM_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[MEM_LAT-1];

    // ---------------- reference model state ----------------
    logic [7:0]        ref_mem [4096];
    logic [4095:0]     ref_wr = '0;
    logic [2:0]        exp_ack = '0;
    logic              exp_en = 1'b0, exp_we = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [7:0]        exp_wd = '0;
    int                m_wait = 0;
    logic [2:0]        slot_rv [8];    // expected rvalid one-hot, by cycle mod 8
    logic [7:0]        slot_dat [8];
    logic [2:0]        log_own [$];
    logic [7:0]        log_dat [$];
    int                log_cyc [$];
    int                ack_cyc [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_ack = '0; exp_en = 1'b0; exp_we = 1'b0; m_wait = 0;
        for (int i = 0; i < 8; i++) begin slot_rv[i] = '0; slot_dat[i] = '0; end
    endtask

    // Decide what the next edge issues, from the inputs now on the pins.
    task automatic predict();
        logic [2:0] elig;
        int win;
        logic [11:0] ix;
        if (!rst_n) begin model_clear(); return; end
        elig = req & ~exp_ack;
        win = -1;
        if (elig[1] && m_wait == MAXW) win = 1;
        else if (elig[0]) win = 0;
        else if (elig[1]) win = 1;
        else if (elig[2]) win = 2;
        if (!req[1] || win == 1) m_wait = 0;
        else if (elig[1] && m_wait < MAXW) m_wait++;
        exp_ack = '0; exp_en = 1'b0; exp_we = 1'b0;
        if (win >= 0) begin
            exp_ack[win] = 1'b1;
            exp_en = 1'b1; exp_we = we[win]; exp_addr = addr[win]; exp_wd = wdata[win];
            ix = addr[win][11:0];
            if (we[win]) begin
                ref_mem[ix] = wdata[win]; ref_wr[ix] = 1'b1;
            end else begin
                slot_rv[(cyc + 1 + MEM_LAT) % 8][win] = 1'b1;
                slot_dat[(cyc + 1 + MEM_LAT) % 8] = ref_wr[ix] ? ref_mem[ix] : dflt(addr[win]);
            end
        end
    endtask

    task automatic check();
        int s;
        logic [2:0] acks, rvs;
        s = cyc % 8;
        acks = {ld_ack, cpu_ack, ppu_ack};
        rvs  = {ld_rvalid, cpu_rvalid, ppu_rvalid};
        chk("ack", 64'(acks), 64'(exp_ack));
        chk("mem_en_we", {mem_en, mem_we}, {exp_en, exp_we});
        if (exp_en) chk("mem_addr_wdata", {mem_addr, mem_wdata}, {exp_addr, exp_wd});
        chk("rvalid", 64'(rvs), 64'(slot_rv[s]));
        chk("rdata", 64'(rdata), (slot_rv[s] != 0) ? 64'(slot_dat[s]) : 64'h0);
        chk("cpu_wait", 64'(dut.cpu_wait_q), 64'(m_wait));
        if (!rst_n) chk("reset_mem_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
        for (int i = 0; i < 3; i++) if (acks[i]) ack_cyc[i] = cyc;
        if (rvs != 0) begin
            log_own.push_back(rvs); log_dat.push_back(rdata); log_cyc.push_back(cyc);
        end
        slot_rv[s] = '0;
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check();
    endtask

    task automatic set_req(input int i, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [7:0] d);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    endtask

    task automatic serve();
        logic [2:0] acks;
        acks = {ld_ack, cpu_ack, ppu_ack};
        for (int i = 0; i < 3; i++) if (req[i] && acks[i]) req[i] = 1'b0;
    endtask

    task automatic run_serve(input int n);
        repeat (n) begin step(); serve(); end
    endtask

    task automatic clear_log();
        log_own.delete(); log_dat.delete(); log_cyc.delete();
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)),
                {6'($urandom_range(0, 63)), 12'($urandom_range(0, 15))},
                8'($urandom_range(0, 255)));
    endtask

    initial begin
        int c0, cpu_seen;
        logic seen;
        logic [2:0] acks;
        for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; ack_cyc[i] = -1; end

        // Reset: everything quiet; loader write waits for rst_n to be sampled high.
        model_clear();
        step(); step();
        set_req(2, 1'b1, 18'h01234, 8'hA5);
        step();
        rst_n = 1'b1;
        c0 = cyc;
        run_serve(3);
        chk("first_grant_after_release", 64'(ack_cyc[2] - c0), 64'd1);

        // Preload for the interleave test.
        set_req(2, 1'b1, 18'h00100, 8'h11); run_serve(3);
        set_req(2, 1'b1, 18'h00101, 8'h22); run_serve(3);
        set_req(2, 1'b1, 18'h00102, 8'h33); run_serve(3);

        // Single PPU read.
        clear_log();
        c0 = cyc;
        set_req(0, 1'b0, 18'h01234, 8'h00);
        run_serve(6);
        chk("single_read", {32'(log_own.size()), 3'(log_own[0]), log_dat[0], 8'(log_cyc[0] - c0)},
            {32'd1, 3'b001, 8'hA5, 8'd3});

        // Three-way contention.
        c0 = cyc;
        set_req(0, 1'b0, 18'h00040, 8'h00);
        set_req(1, 1'b0, 18'h00041, 8'h00);
        set_req(2, 1'b1, 18'h00042, 8'h77);
        run_serve(6);
        chk("contention_order", {16'(ack_cyc[0] - c0), 16'(ack_cyc[1] - c0), 16'(ack_cyc[2] - c0)},
            {16'd1, 16'd2, 16'd3});

        // CPU against a PPU that keeps requesting.
        c0 = cyc;
        cpu_seen = -1;
        set_req(0, 1'b0, 18'h00003, 8'h00);
        set_req(1, 1'b0, 18'h00004, 8'h00);
        for (int k = 0; k < 10; k++) begin
            step();
            acks = {ld_ack, cpu_ack, ppu_ack};
            if (acks[0]) addr[0] = 18'(addr[0] + 1);
            if (acks[1] && cpu_seen < 0) begin cpu_seen = cyc; req[1] = 1'b0; end
        end
        req[0] = 1'b0;
        run_serve(4);
        chk("cpu_not_starved", 64'(cpu_seen >= 0 && cpu_seen - c0 <= 5), 64'd1);

        // Interleaved reads return in issue order.
        clear_log();
        set_req(0, 1'b0, 18'h00100, 8'h00);
        set_req(1, 1'b0, 18'h00101, 8'h00);
        step();
        addr[0] = 18'h00102;
        step();
        req[1] = 1'b0;
        step();
        req[0] = 1'b0;
        run_serve(5);
        chk("interleave_count", 64'(log_own.size()), 64'd3);
        if (log_own.size() == 3)
            chk("interleave_data", {log_own[0], log_dat[0], log_own[1], log_dat[1], log_own[2], log_dat[2]},
                {3'b001, 8'h11, 3'b010, 8'h22, 3'b001, 8'h33});

        // Loader write then CPU read of the same location.
        clear_log();
        set_req(2, 1'b1, 18'h00010, 8'h5A);
        run_serve(2);
        set_req(1, 1'b0, 18'h00010, 8'h00);
        run_serve(6);
        chk("write_then_read", {32'(log_own.size()), 3'(log_own[0]), log_dat[0]},
            {32'd1, 3'b010, 8'h5A});

        // Reset one cycle after a CPU read ack discards the read.
        clear_log();
        set_req(1, 1'b0, 18'h00020, 8'h00);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            seen = cpu_ack;
            serve();
        end
        chk("reset_case_ack", 64'(seen), 64'd1);
        step();
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("async_reset_outputs",
            {ppu_ack, cpu_ack, ld_ack, ppu_rvalid, cpu_rvalid, ld_rvalid, rdata,
             mem_en, mem_we, mem_addr, mem_wdata, dut.cpu_wait_q},
            64'h0);
        step();
        rst_n = 1'b1;
        run_serve(6);
        chk("no_rvalid_after_reset", 64'(log_own.size()), 64'd0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step();
            acks = {ld_ack, cpu_ack, ppu_ack};
            for (int i = 0; i < 3; i++) begin
                if (req[i] && acks[i]) begin
                    if ($urandom_range(0, 1) == 1) rand_req(i);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    rand_req(i);
                end
            end
        end
        req = '0;
        run_serve(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
